// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//   Serial pattern transmitter. On an accepted start it captures a PAT_W-bit
//   pattern and sends it MSB-first on dout_o, one bit per clock, repeat_n_i
//   times with gap_n_i idle cycles between repeats, then pulses done_o.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   reset_i      synchronous active-high reset (wins over start and abort)
//   start_i      burst request, accepted only while ready_o=1
//   abort_i      synchronous abort of a burst in progress
//   pattern_i    bits to send, MSB first, sampled on accept
//   repeat_n_i   number of pattern repeats, sampled on accept
//   gap_n_i      idle cycles between repeats, sampled on accept
//   ready_o      1 in IDLE only
//   busy_o       1 while shifting or in a gap
//   dout_o       serial data, 0 whenever dout_valid_o=0
//   dout_valid_o 1 while a pattern bit is on dout_o
//   done_o       one-cycle pulse after the last bit of a normal burst
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_n_i,
  input  logic [GAP_W-1:0] gap_n_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             done_o
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;       // copy of the pattern for reloads
  logic [PAT_W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   rep_left_q, rep_left_d;
  logic [GAP_W-1:0]   gap_ld_q, gap_ld_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  // Output registers are loaded from the next-state values so that every
  // output is a flop yet carries the same cycle timing as a state decode.
  logic ready_q, busy_q, dout_q, dout_valid_q, done_q;

  // Next-state logic for the FSM and its datapath counters.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    rep_left_d = rep_left_q;
    gap_ld_d   = gap_ld_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE does nothing but still blocks a simultaneous start
        if (start_i && !abort_i) begin
          pat_d      = pattern_i;
          shreg_d    = pattern_i;
          rep_left_d = repeat_n_i;
          gap_ld_d   = gap_n_i;
          bit_cnt_d  = BIT_LAST;
          if (repeat_n_i != {CNT_W{1'b0}}) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BW'(1);
          if (bit_cnt_q == {BW{1'b0}}) begin
            // rep_left is never 0 here, so <=1 only guards against wrap
            if (rep_left_q <= CNT_W'(1)) begin
              state_d = S_DONE;
            end else begin
              rep_left_d = rep_left_q - CNT_W'(1);
              bit_cnt_d  = BIT_LAST;
              if (gap_ld_q == {GAP_W{1'b0}}) begin
                shreg_d = pat_q;
              end else begin
                state_d   = S_GAP;
                gap_cnt_d = gap_ld_q;
              end
            end
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_GAP: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          // reload on the last gap cycle so the first bit follows immediately
          if (gap_cnt_q <= GAP_W'(1)) begin
            gap_cnt_d = {GAP_W{1'b0}};
            shreg_d   = pat_q;
            state_d   = S_SHIFT;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      pat_q        <= {PAT_W{1'b0}};
      shreg_q      <= {PAT_W{1'b0}};
      bit_cnt_q    <= {BW{1'b0}};
      rep_left_q   <= {CNT_W{1'b0}};
      gap_ld_q     <= {GAP_W{1'b0}};
      gap_cnt_q    <= {GAP_W{1'b0}};
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      rep_left_q   <= rep_left_d;
      gap_ld_q     <= gap_ld_d;
      gap_cnt_q    <= gap_cnt_d;
      ready_q      <= (state_d == S_IDLE);
      busy_q       <= (state_d == S_SHIFT) || (state_d == S_GAP);
      dout_q       <= (state_d == S_SHIFT) && shreg_d[PAT_W-1];
      dout_valid_q <= (state_d == S_SHIFT);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
//   Drives directed and random bursts into seq_pattern_tx and compares every
//   cycle's outputs with a reference that derives the expected waveform from
//   the burst timing rules (bit position within repeat period, burst length).
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap_n;
  logic             ready, busy, dout, dout_valid, done;

  int n_checks = 0;
  int n_fail   = 0;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .abort_i     (abort),
    .pattern_i   (pattern),
    .repeat_n_i  (repeat_n),
    .gap_n_i     (gap_n),
    .ready_o     (ready),
    .busy_o      (busy),
    .dout_o      (dout),
    .dout_valid_o(dout_valid),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05b expected %05b (ready,busy,valid,dout,done)", tag, act[4:0], exp[4:0]);
    end
  endtask

  // Expected {ready,busy,valid,dout,done} in cycle c after the accept edge.
  // stop != 0: burst killed (abort or reset) during cycle stop.
  function automatic logic [4:0] model(input logic [PAT_W-1:0] pat, input int rep,
                                       input int gap, input int c, input int stop);
    int len, period, off;
    if (stop != 0 && c > stop) return 5'b10000;
    len = (rep == 0) ? 0 : rep * PAT_W + (rep - 1) * gap;
    if (c <= len) begin
      period = PAT_W + gap;
      off    = (c - 1) % period;
      if (off < PAT_W) return {1'b0, 1'b1, 1'b1, pat[PAT_W-1-off], 1'b0};
      return 5'b01000;
    end
    if (c == len + 1) return 5'b00001;
    return 5'b10000;
  endfunction

  function automatic logic [7:0] obs();
    return {3'b000, ready, busy, dout_valid, dout, done};
  endfunction

  // Called at a falling edge with the DUT idle. mode 0: normal, 1: abort in
  // cycle k, 2: reset in cycle k. Ends at a falling edge with the DUT idle.
  task automatic run_burst(input string tag, input logic [PAT_W-1:0] pat, input int rep,
                           input int gap, input int mode, input int k);
    int len, last, stop;
    len  = (rep == 0) ? 0 : rep * PAT_W + (rep - 1) * gap;
    stop = (mode != 0) ? k : 0;
    last = (mode != 0) ? k + 1 : len + 2;
    pattern  = pat;
    repeat_n = CNT_W'(rep);
    gap_n    = GAP_W'(gap);
    start    = 1'b1;
    abort    = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      check_eq($sformatf("%s c%0d", tag, c), obs(), {3'b000, model(pat, rep, gap, c, stop)});
      // junk on the inputs while the burst owns the DUT must be ignored
      if (c <= len + 1 && (mode == 0 || c <= k)) begin
        start    = 1'($urandom);
        pattern  = PAT_W'($urandom);
        repeat_n = CNT_W'($urandom);
        gap_n    = GAP_W'($urandom);
      end
      if (mode == 1 && c == k) abort = 1'b1;
      if (mode == 2 && c == k) reset = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    int rep, gap, mode, k, len;
    logic [PAT_W-1:0] pat;

    reset = 1'b1; start = 1'b1; abort = 1'b0;
    pattern = 4'b1101; repeat_n = 8'd1; gap_n = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", obs(), 8'b0001_0000);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("after_reset", obs(), 8'b0001_0000);

    run_burst("t1_single",   4'b1101, 1, 0, 0, 0);
    run_burst("t2_contig",   4'b1101, 3, 0, 0, 0);
    run_burst("t3_gap",      4'b1101, 2, 3, 0, 0);
    run_burst("t4_rep0",     4'b1101, 0, 2, 0, 0);
    run_burst("t5_abort",    4'b1101, 3, 0, 1, 6);
    run_burst("t6_reset",    4'b1101, 3, 2, 2, 3);
    run_burst("t6_restart",  4'b1011, 2, 1, 0, 0);
    run_burst("max_gap",     4'b1001, 2, 15, 0, 0);
    run_burst("abort_gap",   4'b0110, 3, 4, 1, 6);
    run_burst("abort_done",  4'b1111, 1, 0, 1, 5);

    // abort in IDLE beats a simultaneous start
    start = 1'b1; abort = 1'b1; pattern = 4'b1111; repeat_n = 8'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("idle_abort_start", obs(), 8'b0001_0000);
    @(negedge clk);
    check_eq("idle_abort_start2", obs(), 8'b0001_0000);

    // reset beats a simultaneous start
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check_eq("reset_start", obs(), 8'b0001_0000);
    @(negedge clk);
    check_eq("reset_start2", obs(), 8'b0001_0000);

    for (int i = 0; i < 60; i++) begin
      pat  = PAT_W'($urandom);
      rep  = $urandom_range(0, 4);
      gap  = $urandom_range(0, 5);
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = 0;
      len  = (rep == 0) ? 0 : rep * PAT_W + (rep - 1) * gap;
      k    = $urandom_range(1, len + 1);
      run_burst($sformatf("rnd%0d", i), pat, rep, gap, mode, k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
